// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch path.
package mips_fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // Full-width bounds check: no truncation, so huge PCs never alias into memory.
  function automatic logic in_range(input logic [WORD_W-1:0] addr, input int depth);
    return addr < WORD_W'(depth);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels between the PC unit (master) and instruction memory (slave).
interface imem_responder_if;
  import mips_fetch_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [WORD_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_instr;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x 32 instruction store: one write port, one strobed synchronous read port.
// Read data is the pre-write contents when both ports hit the same word in one cycle.
module imem_array
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents survive reset so a loaded program persists across core resets.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, WAIT_CYCLES wait states, response 1+WAIT_CYCLES after accept.
// Response held until rsp_ready; req_ready stays low from accept until the response handshake.
module imem_responder
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH       = 256,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [WORD_W-1:0] NOP_WORD    = DEFAULT_NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              busy
);

  localparam int         ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  fetch_state_t      state;
  logic [3:0]        wait_cnt;
  logic [WORD_W-1:0] addr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] rd_addr_full;
  logic              rd_fire;
  logic              rd_hit;
  logic              wr_hit;

  // With zero wait states the read happens in the accept cycle, before addr_q is loaded.
  assign rd_addr_full = (state == IDLE) ? bus.req_addr : addr_q;
  assign rd_fire      = ((state == IDLE) && bus.req_valid && (WAIT_CYCLES == 0))
                     || ((state == WAIT) && (wait_cnt == 4'd1));
  assign rd_hit       = in_range(rd_addr_full, DEPTH);
  assign wr_hit       = load_en && in_range(load_addr, DEPTH);

  imem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_hit),
    .wr_addr (load_addr[ADDR_W-1:0]),
    .wr_data (load_data),
    .rd_en   (rd_fire && rd_hit),
    .rd_addr (rd_addr_full[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            wait_cnt <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= !rd_hit;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !rd_hit;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The array's read register is only refreshed on in-range reads, so the error flag picks NOP here.
  assign bus.rsp_instr = rsp_err_q ? NOP_WORD : rd_word;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) share a load port; one is selected at a time.
module tb_imem_responder;

  localparam logic [31:0] NOP2 = 32'hFC00_0000;
  localparam logic [31:0] NOP0 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        busy2, busy0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_instr;

  int          total = 0;
  int          bad = 0;
  int          rsp_hs = 0;
  logic [31:0] ref_mem [256];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  imem_responder_if bus2 ();
  imem_responder_if bus0 ();

  assign bus2.req_valid = req_valid && !sel;
  assign bus0.req_valid = req_valid && sel;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_addr  = req_addr;
  assign bus2.rsp_ready = rsp_ready;
  assign bus0.rsp_ready = rsp_ready;

  assign req_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign rsp_instr = sel ? bus0.rsp_instr : bus2.rsp_instr;
  assign rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
  assign busy      = sel ? busy0 : busy2;

  imem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .NOP_WORD(NOP2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy2));

  imem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .NOP_WORD(NOP0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: word index below 256 returns the stored word, anything else is NOP with error.
  function automatic logic [32:0] model(input logic [31:0] a, input logic s);
    if (a < 32'd256) return {ref_mem[a[7:0]], 1'b0};
    return {(s ? NOP0 : NOP2), 1'b1};
  endfunction

  always @(negedge clk) begin
    if (!reset && req_valid && req_ready) exp_q.push_back(model(req_addr, sel));
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got instr %0h with nothing outstanding", rsp_instr);
      end else begin
        chk("rsp_instr", rsp_instr, exp_q[0][32:1]);
        chk("rsp_err", rsp_err, exp_q[0][0]);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          rsp_hs++;
        end
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (a < 32'd256) ref_mem[a[7:0]] = d;
  endtask

  // Called one step after a rising edge; returns at the same phase.
  task automatic fetch(input logic [31:0] a, input int hold, input bit coll, input logic [31:0] cdata);
    int n;
    int w;
    w = sel ? 0 : 2;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (coll && n == w - 1) begin load_en = 1'b1; load_addr = a; load_data = cdata; end
      @(posedge clk); #1;
      n++;
      if (load_en) begin
        load_en = 1'b0;
        if (a < 32'd256) ref_mem[a[7:0]] = cdata;
      end
    end
    chk("rsp_latency", n, w);
    repeat (hold) begin
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    int r;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_instr", rsp_instr, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
    end
    sel = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) load(i, $urandom);
    load(0, 32'h2008_0005);
    load(1, 32'h2009_0003);
    load(2, 32'h0109_5020);
    load(3, 32'h0000_0000);

    fetch(2, 0, 0, 0);
    chk("ref_word2", ref_mem[2], 32'h0109_5020);
    fetch($urandom_range(0, 255), 5, 0, 0);
    fetch(256, 0, 0, 0);
    fetch(32'hFFFF_FFFF, 2, 0, 0);
    load(300, 32'h1234_5678);
    fetch(44, 0, 0, 0);
    fetch(300, 0, 0, 0);

    sel = 1'b1;
    fetch(1, 0, 0, 0);
    fetch(300, 1, 0, 0);
    req_valid = 1'b1; rsp_ready = 1'b1; req_addr = 1;
    base = rsp_hs;
    repeat (10) begin
      @(posedge clk); #1;
      req_addr = $urandom_range(0, 300);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("b2b_count", rsp_hs - base, 5);

    sel = 1'b0;
    fetch(1, 0, 1, 32'hDEAD_BEEF);
    fetch(1, 0, 0, 0);
    chk("ref_word1", ref_mem[1], 32'hDEAD_BEEF);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 7) a = $urandom_range(0, 255);
      else if (r == 7) a = $urandom_range(256, 300);
      else if (r == 8) a = $urandom;
      else a = 255;
      fetch(a, $urandom_range(0, 3), 0, 0);
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, 300), $urandom);
    end

    sel = 1'b0;
    req_valid = 1'b1; req_addr = 3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    load_en = 1'b1; load_addr = 5; load_data = 32'hCAFE_0005;
    @(posedge clk); #1;
    reset = 1'b0; load_en = 1'b0;
    ref_mem[5] = 32'hCAFE_0005;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    cnt = 0;
    repeat (6) begin
      if (rsp_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", cnt, 0);
    fetch(3, 0, 0, 0);
    fetch(5, 0, 0, 0);
    fetch(1, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
